// File: rtl/ram_burst_reader.sv
// Burst reader: streams len words from a registered-read dual-port RAM,
// starting at base_addr and wrapping at DEPTH, through a 2-entry skid FIFO.
module ram_burst_reader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 34
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_LEN = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH+1)'(1);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH:0]     issued_q, issued_d;
  logic                    inflight_q, inflight_d;
  logic                    inflight_last_q, inflight_last_d;
  logic [DATA_WIDTH-1:0]   fifo_data_q [2];
  logic [DATA_WIDTH-1:0]   fifo_data_d [2];
  logic                    fifo_last_q [2];
  logic                    fifo_last_d [2];
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [1:0]              count_q, count_d;
  logic                    done_q, done_d;

  logic [ADDR_WIDTH:0]     len_clamped;
  logic                    push;
  logic                    pop;
  logic                    issue;
  logic                    issue_last;

  always_comb begin
    len_clamped = (len > DEPTH_LEN) ? DEPTH_LEN : len;
    push        = inflight_q;
    pop         = (count_q != 2'd0) && m_ready;
    // A same-cycle pop frees a slot, so the pipeline can keep one word per cycle.
    issue       = (state_q == READ) && (issued_q < len_q) &&
                  ((({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2) || pop);
    issue_last  = (issued_q == (len_q - LEN_ONE));
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    len_d           = len_q;
    issued_d        = issued_q;
    done_d          = 1'b0;
    inflight_d      = issue;
    inflight_last_d = issue && issue_last;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = READ;
            ptr_d    = base_addr;
            len_d    = len_clamped;
            issued_d = '0;
          end
        end
      end
      READ: begin
        if (pop && fifo_last_q[rd_q]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      ptr_d    = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_WIDTH'(1);
      issued_d = issued_q + LEN_ONE;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fifo_data_d[i] = fifo_data_q[i];
      fifo_last_d[i] = fifo_last_q[i];
    end
    wr_d = wr_q;
    rd_d = rd_q;

    if (push) begin
      fifo_data_d[wr_q] = ram_dout;
      fifo_last_d[wr_q] = inflight_last_q;
      wr_d              = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rd_q            <= 1'b0;
      wr_q            <= 1'b0;
      count_q         <= 2'd0;
      done_q          <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      rd_q            <= rd_d;
      wr_q            <= wr_d;
      count_q         <= count_d;
      done_q          <= done_d;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= fifo_data_d[i];
        fifo_last_q[i] <= fifo_last_d[i];
      end
    end
  end

  assign ram_addr = ptr_q;
  assign ram_we   = 1'b0;
  assign ram_din  = '0;
  assign m_valid  = (count_q != 2'd0);
  assign m_data   = fifo_data_q[rd_q];
  assign m_last   = m_valid && fifo_last_q[rd_q];
  assign busy     = (state_q == READ);
  assign done     = done_q;

`ifndef SYNTHESIS
  // Issue throttling keeps buffered + in-flight <= 2, so a full FIFO never sees a push.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == 2'd2)));
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomized bench for ram_burst_reader: expected beats come from a simple
// list model (mem[(base+i) % DEPTH], i < min(len, DEPTH)).
module tb_ram_burst_reader;
  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 34;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  int vectors     = 0;
  int miscompares = 0;

  ram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_dout <= (int'(ram_addr) < DEPTH) ? mem[ram_addr] : '0;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, int'(m_valid), 0);
    check_val({tag, "_last"},  int'(m_last), 0);
    check_val({tag, "_data"},  int'(m_data), 0);
    check_val({tag, "_busy"},  int'(busy), 0);
    check_val({tag, "_done"},  int'(done), 0);
    check_val({tag, "_addr"},  int'(ram_addr), 0);
    check_val({tag, "_we"},    int'(ram_we), 0);
    check_val({tag, "_din"},   int'(ram_din), 0);
  endtask

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0,1,..., 2 = random ready
  task automatic run_burst(input int base, input int blen, input int rmode,
                           input bit poke, input bit rst_mid);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] held_data;
    logic          held_last;
    int            n;
    int            idx;
    int            k;
    bit            stall;
    bit            finished;

    n = (blen > DEPTH) ? DEPTH : blen;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(base + i) % DEPTH]);

    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(base);
    len       = (AW+1)'(blen);
    m_ready   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k     = 1;

    if (n == 0) begin
      check_val("zero_done", int'(done), 1);
      check_val("zero_busy", int'(busy), 0);
      check_val("zero_valid", int'(m_valid), 0);
      @(negedge clk);
      check_val("zero_done_pulse", int'(done), 0);
      check_val("zero_valid2", int'(m_valid), 0);
      $display("burst base=%0d len=%0d mode=%0d beats=0/0", base, blen, rmode);
      return;
    end

    idx       = 0;
    stall     = 1'b0;
    finished  = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    while (!finished && k < 400) begin
      if (rmode == 0 && k <= n)
        check_val("ram_addr_seq", int'(ram_addr), (base + k - 1) % DEPTH);
      if (rmode == 0 && k < 3)
        check_val("latency_valid_low", int'(m_valid), 0);

      if (rst_mid && idx == 2) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check_val("post_rst_valid", int'(m_valid), 0);
          check_val("post_rst_done", int'(done), 0);
          check_val("post_rst_busy", int'(busy), 0);
        end
        $display("burst base=%0d len=%0d mode=%0d beats=%0d/%0d (reset mid-burst)",
                 base, blen, rmode, idx, n);
        return;
      end

      if (stall) begin
        check_val("stall_valid", int'(m_valid), 1);
        check_val("stall_data", int'(m_data), int'(held_data));
        check_val("stall_last", int'(m_last), int'(held_last));
      end
      check_val("busy_active", int'(busy), 1);
      check_val("done_early", int'(done), 0);

      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (((k - 1) % 4) == 0) || (((k - 1) % 4) == 3);
        default: m_ready = ($urandom_range(0, 9) < 6);
      endcase

      if (poke && k == 5) begin
        start     = 1'b1;
        base_addr = AW'((base + 7) % DEPTH);
        len       = (AW+1)'(3);
      end else begin
        start = 1'b0;
      end

      if (m_valid && m_ready) begin
        check_val("beat_data", int'(m_data), int'(exp_q[idx]));
        check_val("beat_last", int'(m_last), (idx == n - 1) ? 1 : 0);
        if (rmode == 0) check_val("beat_cycle", k, 3 + idx);
        idx++;
        if (idx == n) finished = 1'b1;
      end
      stall     = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;

      @(negedge clk);
      k++;
    end
    start = 1'b0;

    if (!finished) begin
      check_val("burst_timeout", idx, n);
    end else begin
      check_val("done_pulse", int'(done), 1);
      check_val("busy_end", int'(busy), 0);
      check_val("valid_end", int'(m_valid), 0);
      @(negedge clk);
      check_val("done_single", int'(done), 0);
    end
    $display("burst base=%0d len=%0d mode=%0d beats=%0d/%0d", base, blen, rmode, idx, n);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 16);
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_burst(0, 4, 0, 1'b0, 1'b0);
    run_burst(32, 4, 0, 1'b0, 1'b0);
    run_burst(5, 6, 1, 1'b0, 1'b0);
    run_burst(7, 0, 0, 1'b0, 1'b0);
    run_burst(10, 40, 2, 1'b1, 1'b0);
    run_burst(3, 8, 0, 1'b0, 1'b1);
    run_burst(0, 34, 1, 1'b1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
